sb_tx_arbiter: RTL
==================

SB_TX_ARBITER -- requirements
Module: sb_tx_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, number of SEND cycles allowed before timeout; legal range 2..255.
REQ-002 SHALL have port CLK  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port i_enable  input  1  arbitration enabled (REPAIRMB state active).
REQ-005 SHALL have port i_req_tx  input  1  send request from the transmitter-side requester.
REQ-006 SHALL have port i_msg_tx  input  4  sideband message code from the tx-side requester.
REQ-007 SHALL have port i_info_tx  input  3  message info from the tx-side requester.
REQ-008 SHALL have port i_req_rx  input  1  send request from the partner (rx-side) requester.
REQ-009 SHALL have port i_msg_rx  input  4  sideband message code from the partner requester.
REQ-010 SHALL have port i_info_rx  input  3  message info from the partner requester.
REQ-011 SHALL have port i_falling_edge_busy  input  1  sideband finished the current message.
REQ-012 SHALL have port o_TX_SbMessage  output  4  granted message code to sideband.
REQ-013 SHALL have port o_msg_info  output  3  granted message info to sideband.
REQ-014 SHALL have port o_ValidOutData  output  1  sideband message valid.
REQ-015 SHALL have port o_ack_tx  output  1  one-cycle done pulse to the tx-side requester.
REQ-016 SHALL have port o_ack_rx  output  1  one-cycle done pulse to the partner requester.
REQ-017 SHALL have port o_timeout  output  1  one-cycle pulse when the sideband never completed.
REQ-018 SHALL have port o_grant_rx  output  1  owner of the current or last grant: 0=tx, 1=rx.

Function
REQ-019 SHALL implement FSM states IDLE, SEND, DONE, TOUT; the reset state SHALL be IDLE.
REQ-020 IDLE: a request SHALL be eligible only if its req=1 and its msg!=4'b0000; a request with msg 0 SHALL be ignored and never acked.
REQ-021 IDLE: with i_enable=1 and at least one eligible request, SHALL latch the winner's msg/info, set o_grant_rx, clear the counter, and go to SEND next cycle.
REQ-022 Arbitration SHALL be round-robin: when both are eligible, the requester not granted last wins; the last-grant pointer resets to rx so that tx wins first.
REQ-023 SEND: SHALL drive o_ValidOutData=1 with the latched msg/info, stable for the whole state; input changes and request drops SHALL be ignored until exit.
REQ-024 SEND: i_falling_edge_busy=1 SHALL cause a transition to DONE.
REQ-025 SEND: the counter SHALL increment each cycle; when count==TIMEOUT_CYCLES-1 with no edge, SHALL go to TOUT; the counter is 8 bits and saturates, never wraps.
REQ-026 If the falling edge and the timeout condition occur in the same cycle, the edge SHALL win (DONE).
REQ-027 DONE: SHALL pulse the granted requester's ack for exactly 1 cycle, update the last-grant pointer, then go to IDLE.
REQ-028 TOUT: SHALL pulse o_timeout for 1 cycle with no ack, update the last-grant pointer, then go to IDLE.
REQ-029 i_enable=0 in SEND SHALL abort to IDLE next cycle with no ack, no timeout pulse, and the pointer unchanged.
REQ-030 Outside SEND, o_TX_SbMessage=0, o_msg_info=0 and o_ValidOutData=0.
REQ-031 Latency: req sampled in IDLE at cycle N -> valid at N+1; edge at cycle M -> ack at M+1; minimum back-to-back spacing is 1 idle cycle.
REQ-032 i_falling_edge_busy outside SEND SHALL be ignored.

Reset
REQ-033 rst=1 SHALL, on the next edge, force IDLE, counter=0, pointer=rx, and all outputs 0 (including o_grant_rx), regardless of state.
REQ-034 Reset asserted mid-SEND SHALL drop o_ValidOutData the following cycle and produce no ack or timeout.

Verification
REQ-035 Only tx requests, msg=4'h5, info=3'd2; edge 3 cycles later -> valid=1 with 5/2 for 3 cycles, o_ack_tx a 1-cycle pulse, o_ack_rx=0.
REQ-036 Both request continuously, with an edge every SEND -> grants alternate tx, rx, tx, rx; each ack is 1 cycle.
REQ-037 Single request with no edge, TIMEOUT_CYCLES=16 -> valid high for 16 cycles, then o_timeout pulse, no ack, return to IDLE.
REQ-038 Edge coincident with count==15 -> o_ack asserted, o_timeout=0.
REQ-039 i_enable dropped, and separately rst raised, during SEND -> valid=0 next cycle with no ack/timeout; after rst, the first contested grant goes to tx.
REQ-040 req=1 with msg=0 -> stays IDLE, valid=0, no ack.

Source files
------------

// File: rtl/sb_tx_arbiter.sv
// Sideband transmit arbiter: picks one of two message requesters round-robin,
// holds the granted message on the sideband until it reports completion,
// then acknowledges the owner (or flags a timeout if completion never comes).
module sb_tx_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       i_enable,
  input  logic       i_req_tx,
  input  logic [3:0] i_msg_tx,
  input  logic [2:0] i_info_tx,
  input  logic       i_req_rx,
  input  logic [3:0] i_msg_rx,
  input  logic [2:0] i_info_rx,
  input  logic       i_falling_edge_busy,
  output logic [3:0] o_TX_SbMessage,
  output logic [2:0] o_msg_info,
  output logic       o_ValidOutData,
  output logic       o_ack_tx,
  output logic       o_ack_rx,
  output logic       o_timeout,
  output logic       o_grant_rx
);

  typedef enum logic [1:0] {IDLE, SEND, DONE, TOUT} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] msg_q, msg_d;
  logic [2:0] info_q, info_d;
  logic       grant_rx_q, grant_rx_d;
  logic       last_rx_q, last_rx_d;
  logic       elig_tx, elig_rx, pick_rx;

  // Counter stops at all-ones instead of wrapping back to zero.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A message code of zero means "nothing to send" even if req is high.
  assign elig_tx = i_req_tx && (i_msg_tx != 4'b0000);
  assign elig_rx = i_req_rx && (i_msg_rx != 4'b0000);
  // rx wins only when it is alone, or when tx was the previous owner.
  assign pick_rx = elig_rx && (!elig_tx || !last_rx_q);

  // State register.
  always_ff @(posedge CLK) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: completion edge beats timeout; disable beats everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (i_enable && (elig_tx || elig_rx)) state_d = SEND;
      SEND: begin
        if (!i_enable)                 state_d = IDLE;
        else if (i_falling_edge_busy)  state_d = DONE;
        else if (cnt_q == CNT_LAST)    state_d = TOUT;
      end
      DONE:    state_d = IDLE;
      TOUT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and latched-message registers; the message payload needs no reset
  // because it is only visible while in SEND.
  always_ff @(posedge CLK) begin
    if (rst) begin
      cnt_q      <= 8'd0;
      grant_rx_q <= 1'b0;
      last_rx_q  <= 1'b1;
    end else begin
      cnt_q      <= cnt_d;
      grant_rx_q <= grant_rx_d;
      last_rx_q  <= last_rx_d;
    end
    msg_q  <= msg_d;
    info_q <= info_d;
  end

  // Grant capture in IDLE, cycle counting in SEND, pointer update on completion.
  always_comb begin
    cnt_d      = cnt_q;
    msg_d      = msg_q;
    info_d     = info_q;
    grant_rx_d = grant_rx_q;
    last_rx_d  = last_rx_q;
    case (state_q)
      IDLE: begin
        if (i_enable && (elig_tx || elig_rx)) begin
          grant_rx_d = pick_rx;
          msg_d      = pick_rx ? i_msg_rx  : i_msg_tx;
          info_d     = pick_rx ? i_info_rx : i_info_tx;
          cnt_d      = 8'd0;
        end
      end
      SEND:       cnt_d     = sat_inc(cnt_q);
      DONE, TOUT: last_rx_d = grant_rx_q;
      default: ;
    endcase
  end

  // Outputs are decoded purely from the current state.
  always_comb begin
    o_TX_SbMessage = 4'd0;
    o_msg_info     = 3'd0;
    o_ValidOutData = 1'b0;
    o_ack_tx       = 1'b0;
    o_ack_rx       = 1'b0;
    o_timeout      = 1'b0;
    case (state_q)
      SEND: begin
        o_TX_SbMessage = msg_q;
        o_msg_info     = info_q;
        o_ValidOutData = 1'b1;
      end
      DONE: begin
        o_ack_tx = !grant_rx_q;
        o_ack_rx = grant_rx_q;
      end
      TOUT:    o_timeout = 1'b1;
      default: ;
    endcase
  end

  assign o_grant_rx = grant_rx_q;

endmodule
